// File: rtl/cla_adder.sv
// cla_adder: registered 32-bit three-level carry-lookahead adder, o/cout = a + b.
// Define CLA_INREG_EN to register a/b first (2-cycle latency instead of 1).
module cla_adder (
  output logic [31:0] o,
  output logic        cout,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        clk,
  input  logic        rst_n
);
  function automatic logic [3:0] carries(input logic [3:0] g, input logic [3:0] p, input logic ci);
    carries[0] = ci;
    carries[1] = g[0] | p[0] & ci;
    carries[2] = g[1] | p[1] & g[0] | p[1] & p[0] & ci;
    carries[3] = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & ci;
  endfunction

  function automatic logic group_g(input logic [3:0] g, input logic [3:0] p);
    return g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0];
  endfunction

  logic [31:0] x, y, g, p, c;
  logic [7:0]  bg, bp, bc;
  logic [1:0]  sg, sp, sc;
  logic        c0, co;

`ifdef CLA_INREG_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= a;
      y <= b;
    end
`else
  assign x = a;
  assign y = b;
`endif

  assign g = x & y;
  assign p = x ^ y;

  for (genvar i = 0; i < 8; i++) begin : l1
    assign c[4*i +: 4] = carries(g[4*i +: 4], p[4*i +: 4], bc[i]);
    assign bg[i] = group_g(g[4*i +: 4], p[4*i +: 4]);
    assign bp[i] = &p[4*i +: 4];
  end

  // Each 16-bit section feeds all four of its block carry-ins, so nothing ripples between blocks.
  for (genvar i = 0; i < 2; i++) begin : l2
    assign bc[4*i +: 4] = carries(bg[4*i +: 4], bp[4*i +: 4], sc[i]);
    assign sg[i] = group_g(bg[4*i +: 4], bp[4*i +: 4]);
    assign sp[i] = &bp[4*i +: 4];
  end

  assign c0 = 1'b0;
  assign sc = {sg[0] | sp[0] & c0, c0};
  assign co = sg[1] | sp[1] & sg[0] | sp[1] & sp[0] & c0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {cout, o} <= '0;
    else {cout, o} <= {co, p ^ c};
endmodule

// File: tb/tb_cla_adder.sv
// tb_cla_adder: table-driven vectors and random stream through a latency-aware scoreboard.
module tb_cla_adder;
`ifdef CLA_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] o;
    logic        c;
  } vec_t;

  logic        clk, rst_n, cout;
  logic [31:0] a, b, o;
  logic [32:0] q[$];
  int          checks = 0;
  int          fails = 0;
  vec_t        tbl[7];

  cla_adder dut (.o(o), .cout(cout), .a(a), .b(b), .clk(clk), .rst_n(rst_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string n, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic prime();
    q.delete();
    repeat (LAT - 1) q.push_back(33'h0);
  endtask

  task automatic step(input logic [31:0] x, input logic [31:0] y, input logic [32:0] e, input string n);
    a = x;
    b = y;
    @(posedge clk);
    q.push_back(e);
    #1 check(n, {cout, o}, q.pop_front());
  endtask

  initial begin
    logic [31:0] x, y;
    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    tbl[1] = '{32'd24,       32'd56,       32'h00000050, 1'b0};
    tbl[2] = '{32'd245451,   32'd4656556,  32'h004ACC77, 1'b0};
    tbl[3] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    tbl[4] = '{32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0};
    tbl[5] = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
    tbl[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1};
    rst_n = 1'b1;
    a = 32'hFFFFFFFF;
    b = 32'h00000001;
    #1 rst_n = 1'b0;
    #1 check("reset_async", {cout, o}, 33'h0);
    repeat (3) begin
      @(posedge clk);
      #1 check("reset_hold", {cout, o}, 33'h0);
    end
    #2 rst_n = 1'b1;
    prime();
    for (int i = 0; i < 7; i++)
      step(tbl[i].a, tbl[i].b, {tbl[i].c, tbl[i].o}, $sformatf("vec%0d", i));
    for (int i = 0; i < 1000; i++) begin
      x = $urandom;
      y = $urandom;
      step(x, y, {1'b0, x} + {1'b0, y}, "random");
      if (i == 500) begin
        #3 rst_n = 1'b0;
        #1 check("reset_mid", {cout, o}, 33'h0);
        #1 rst_n = 1'b1;
        prime();
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
